axi4_burst_addr_gen: RTL and testbench
======================================

Name: axi4_burst_addr_gen

Overview:
- Parametrised AXI4 burst address generator.
- Accepts one AW/AR-style burst descriptor (addr, len, size, burst type) per handshake and emits a per-beat stream of byte address, memory word index, last flag and response code under valid/ready flow control.
- Sits between the slave's address-channel front end and the memory array, serving both read and write paths (one instance per path).
- Generalises the fixed-type handling to FIXED/INCR/WRAP, variable size, 4KB-boundary checks and range decode.

Parameters:
ADDR_WIDTH, 16, byte address width.
DATA_WIDTH, 32, data bus width in bits (8..1024, power of 2); max legal size = log2(DATA_WIDTH/8).
MEM_DEPTH, 1024, memory depth in DATA_WIDTH words; legal addresses are 0 .. MEM_DEPTH*DATA_WIDTH/8-1.

Ports:
ACLK  in  1  clock, all state on rising edge
ARESETn  in  1  asynchronous active-low reset
req_valid  in  1  descriptor valid
req_ready  out  1  generator can accept descriptor
req_addr  in  ADDR_WIDTH  start byte address
req_len  in  8  beats minus one (AxLEN)
req_size  in  3  axi_size_t (AxSIZE)
req_burst  in  2  axi_burst_t (AxBURST)
beat_valid  out  1  current beat valid
beat_ready  in  1  consumer accepts beat
beat_addr  out  ADDR_WIDTH  byte address of current beat
beat_index  out  $clog2(MEM_DEPTH)  word index = beat_addr >> log2(DATA_WIDTH/8), truncated
beat_num  out  8  beat number 0..req_len
beat_last  out  1  final beat of burst
beat_resp  out  2  axi_resp_t for this beat
busy  out  1  burst in progress

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=1 after release; beat_valid=0, beat_addr=0, beat_num=0, beat_last=0, beat_resp=OKAY, busy=0. Reset mid-burst discards the burst immediately.
- States:
  - IDLE: req_ready=1; on req_valid&&req_ready latch descriptor, compute burst error, go to BURST.
  - BURST: req_ready=0, busy=1, beat_valid=1.
- Latency: descriptor accepted at edge N, beat 0 valid in cycle N+1.
- Beat accepted on beat_valid&&beat_ready: advance beat_num and address. On the last beat (beat_num==len) return to IDLE; req_ready=1 in the next cycle, so no same-cycle back-to-back.
- While beat_valid && !beat_ready, all beat_* outputs are held stable.
- Descriptor inputs are ignored outside the accept cycle.
- bytes = 1<<size; total = bytes*(len+1); all arithmetic modulo 2^ADDR_WIDTH.
- FIXED: every beat = start addr.
- INCR: beat0 = start; beat i>0 = (start aligned down to bytes) + i*bytes.
- WRAP: lower = start aligned down to total; next = cur+bytes; if next == lower+total then next = lower.
- Burst error → SLVERR on every beat; addresses still generated normally. Any one of:
  - size > log2(DATA_WIDTH/8)
  - burst==RSVD (treat addressing as FIXED)
  - WRAP with len not in {1,3,7,15}
  - WRAP with start not size-aligned
  - INCR with start[11:0]+total > 4096
- Per-beat DECERR when beat_addr >= MEM_DEPTH*DATA_WIDTH/8.
- Response precedence: SLVERR > DECERR > OKAY.
- len=0: single beat with beat_last=1.

Decomposition:
- Shared package enuming: reuse axi_burst_t, axi_size_t, axi_resp_t. Add:
  - constant AXI_4KB_BOUNDARY=4096
  - typedef enum {AG_IDLE, AG_BURST} addr_gen_state_e
- One natural combinational sub-module, axi4_next_addr: given current addr, start, size, len and burst, returns the next beat address. Reusable by the checker/scoreboard.

Test Plan:
(DATA_WIDTH=32, MEM_DEPTH=1024, ADDR_WIDTH=16)
1. INCR addr=0x0004 len=3 size=2, beat_ready=1 → beats 0x0004,0x0008,0x000C,0x0010; index 1..4; beat_last only on 4th; all OKAY; req_ready high 1 cycle after last.
2. WRAP addr=0x0038 len=3 size=2 → 0x0038,0x003C,0x0030,0x0034, OKAY. WRAP len=2 → all 3 beats SLVERR.
3. FIXED addr=0x0100 len=2 size=2 → 0x0100 ×3, OKAY. Unaligned INCR addr=0x0005 len=1 size=2 → 0x0005,0x0008.
4. INCR addr=0x0FF8 len=3 size=2 → 0x0FF8,0x0FFC,0x1000,0x1004, all SLVERR (4KB cross overrides DECERR). Size=3 → all SLVERR.
5. FIXED addr=0x1000 len=0 → single beat DECERR, beat_last=1.
6. Hold beat_ready=0 for 3 cycles at beat 1 → beat_addr/beat_num stable. Assert ARESETn=0 mid-burst → beat_valid=0 and busy=0 immediately; req_ready=1 after release.

Source files
------------

// File: rtl/axi4_burst_addr_gen_pkg.sv
// Shared AXI4 address-channel types and constants for the burst address generator.
//   axi_burst_t      : AxBURST encoding (FIXED/INCR/WRAP/RSVD)
//   axi_size_t       : AxSIZE encoding (bytes per beat = 1 << size)
//   axi_resp_t       : xRESP encoding
//   addr_gen_state_e : generator FSM states
package axi4_burst_addr_gen_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_t;

    typedef enum logic [2:0] {
        AXI_SIZE_1B   = 3'd0,
        AXI_SIZE_2B   = 3'd1,
        AXI_SIZE_4B   = 3'd2,
        AXI_SIZE_8B   = 3'd3,
        AXI_SIZE_16B  = 3'd4,
        AXI_SIZE_32B  = 3'd5,
        AXI_SIZE_64B  = 3'd6,
        AXI_SIZE_128B = 3'd7
    } axi_size_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    localparam int unsigned AXI_4KB_BOUNDARY = 4096;

    typedef enum logic [0:0] {
        AG_IDLE  = 1'b0,
        AG_BURST = 1'b1
    } addr_gen_state_e;

endpackage

// File: rtl/axi4_burst_addr_gen_next_addr.sv
// Combinational next-beat address calculator (module axi4_next_addr).
//   cur_addr_i   : address of the beat being accepted
//   start_addr_i : burst start address
//   size_i       : AxSIZE
//   len_i        : AxLEN (beats minus one)
//   burst_i      : AxBURST; RSVD addresses like FIXED
//   next_addr_o  : address of the following beat (modulo 2^ADDR_WIDTH)
module axi4_next_addr
    import axi4_burst_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [2:0]            size_i,
    input  logic [7:0]            len_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] total;
    logic [ADDR_WIDTH-1:0] lower;
    logic [ADDR_WIDTH-1:0] step;

    always_comb begin
        bytes       = ADDR_WIDTH'(1) << size_i;
        total       = bytes * (ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1));
        lower       = start_addr_i & ~(total - ADDR_WIDTH'(1));
        step        = cur_addr_i + bytes;
        next_addr_o = start_addr_i;
        case (burst_i)
            // Aligning the current address makes an unaligned first beat land on the
            // next size boundary; later beats are already aligned.
            AXI_BURST_INCR: next_addr_o = (cur_addr_i & ~(bytes - ADDR_WIDTH'(1))) + bytes;
            AXI_BURST_WRAP: next_addr_o = (step == lower + total) ? lower : step;
            default:        next_addr_o = start_addr_i;
        endcase
    end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst address generator: takes one burst descriptor per handshake and
// produces a per-beat stream of byte address, word index, beat number, last flag
// and response under valid/ready flow control.
//   ACLK, ARESETn                  : clock, async active-low reset
//   req_valid/req_ready            : descriptor handshake
//   req_addr/len/size/burst        : AxADDR/AxLEN/AxSIZE/AxBURST
//   beat_valid/beat_ready          : beat handshake
//   beat_addr/index/num/last/resp  : per-beat outputs, stable while stalled
//   busy                           : burst in progress
module axi4_burst_addr_gen
    import axi4_burst_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [7:0]                   req_len,
    input  logic [2:0]                   req_size,
    input  logic [1:0]                   req_burst,
    output logic                         beat_valid,
    input  logic                         beat_ready,
    output logic [ADDR_WIDTH-1:0]        beat_addr,
    output logic [$clog2(MEM_DEPTH)-1:0] beat_index,
    output logic [7:0]                   beat_num,
    output logic                         beat_last,
    output logic [1:0]                   beat_resp,
    output logic                         busy
);

    localparam int unsigned OffW     = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IdxW     = $clog2(MEM_DEPTH);
    localparam int unsigned MaxSize  = OffW;
    localparam int unsigned MemBytes = MEM_DEPTH * (DATA_WIDTH / 8);

    addr_gen_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            num_q, num_d;
    logic                  slverr_q, slverr_d;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [31:0]           req_bytes;
    logic [31:0]           req_total;
    logic [ADDR_WIDTH-1:0] req_align_mask;
    logic                  req_err;
    logic                  decerr;

    axi4_next_addr #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_next_addr (
        .cur_addr_i  (addr_q),
        .start_addr_i(start_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    // Burst-level error, evaluated on the incoming descriptor and latched at accept.
    always_comb begin
        req_bytes      = 32'd1 << req_size;
        req_total      = req_bytes * (32'(req_len) + 32'd1);
        req_align_mask = ADDR_WIDTH'(req_bytes - 32'd1);
        req_err        = 1'b0;
        if (32'(req_size) > MaxSize) req_err = 1'b1;
        if (req_burst == AXI_BURST_RSVD) req_err = 1'b1;
        if (req_burst == AXI_BURST_WRAP) begin
            if (!(req_len inside {8'd1, 8'd3, 8'd7, 8'd15})) req_err = 1'b1;
            if (|(req_addr & req_align_mask)) req_err = 1'b1;
        end
        if (req_burst == AXI_BURST_INCR) begin
            if ((32'(req_addr[11:0]) + req_total) > AXI_4KB_BOUNDARY) req_err = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        start_d  = start_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        num_d    = num_q;
        slverr_d = slverr_q;
        case (state_q)
            AG_IDLE: begin
                if (req_valid) begin
                    state_d  = AG_BURST;
                    addr_d   = req_addr;
                    start_d  = req_addr;
                    len_d    = req_len;
                    size_d   = req_size;
                    burst_d  = req_burst;
                    num_d    = 8'd0;
                    slverr_d = req_err;
                end
            end
            AG_BURST: begin
                if (beat_ready) begin
                    if (num_q == len_q) begin
                        state_d = AG_IDLE;
                    end else begin
                        num_d  = num_q + 8'd1;
                        addr_d = next_addr;
                    end
                end
            end
            default: state_d = AG_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= AG_IDLE;
            addr_q   <= '0;
            start_q  <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            num_q    <= '0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            start_q  <= start_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            num_q    <= num_d;
            slverr_q <= slverr_d;
        end
    end

    assign decerr = (32'(addr_q) >= MemBytes);

    always_comb begin
        req_ready  = (state_q == AG_IDLE);
        beat_valid = (state_q == AG_BURST);
        busy       = (state_q == AG_BURST);
        beat_addr  = addr_q;
        beat_index = addr_q[OffW +: IdxW];
        beat_num   = num_q;
        beat_last  = beat_valid && (num_q == len_q);
        beat_resp  = AXI_RESP_OKAY;
        if (beat_valid) begin
            if (slverr_q) beat_resp = AXI_RESP_SLVERR;
            else if (decerr) beat_resp = AXI_RESP_DECERR;
        end
    end

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Self-checking bench for axi4_burst_addr_gen (ADDR_WIDTH=16, DATA_WIDTH=32,
// MEM_DEPTH=1024): directed bursts followed by random bursts, all checked against
// an arithmetic reference model.
module tb_axi4_burst_addr_gen;

    logic        ACLK;
    logic        ARESETn;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;
    logic        beat_valid;
    logic        beat_ready;
    logic [15:0] beat_addr;
    logic [9:0]  beat_index;
    logic [7:0]  beat_num;
    logic        beat_last;
    logic [1:0]  beat_resp;
    logic        busy;

    int total_cnt = 0;
    int bad_cnt   = 0;

    axi4_burst_addr_gen #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32),
        .MEM_DEPTH (1024)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_size  (req_size),
        .req_burst (req_burst),
        .beat_valid(beat_valid),
        .beat_ready(beat_ready),
        .beat_addr (beat_addr),
        .beat_index(beat_index),
        .beat_num  (beat_num),
        .beat_last (beat_last),
        .beat_resp (beat_resp),
        .busy      (busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference address of beat i, from the burst rules in closed form.
    function automatic int model_addr(int a, int l, int s, int b, int i);
        int bytes;
        int total;
        int lower;
        bytes = 1 << s;
        total = bytes * (l + 1);
        if (b == 1) begin
            if (i == 0) return a;
            return ((a / bytes) * bytes + i * bytes) & 16'hFFFF;
        end else if (b == 2) begin
            lower = a - (a % total);
            return (lower + ((a - lower) + i * bytes) % total) & 16'hFFFF;
        end
        return a;
    endfunction

    function automatic bit model_slverr(int a, int l, int s, int b);
        int bytes;
        int total;
        bytes = 1 << s;
        total = bytes * (l + 1);
        if (s > 2) return 1'b1;
        if (b == 3) return 1'b1;
        if (b == 2 && !(l inside {1, 3, 7, 15})) return 1'b1;
        if (b == 2 && (a % bytes) != 0) return 1'b1;
        if (b == 1 && (a % 4096) + total > 4096) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_resp(bit slv, int addr);
        if (slv) return 2;
        if (addr >= 4096) return 3;
        return 0;
    endfunction

    task automatic check_beat(input string tag, input int i, input int l, input int ea,
                              input bit slv);
        chk({tag, ".valid"}, 32'(beat_valid), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".addr"}, 32'(beat_addr), 32'(ea));
        chk({tag, ".index"}, 32'(beat_index), 32'((ea >> 2) & 32'h3FF));
        chk({tag, ".num"}, 32'(beat_num), 32'(i));
        chk({tag, ".last"}, 32'(beat_last), 32'(i == l));
        chk({tag, ".resp"}, 32'(beat_resp), 32'(model_resp(slv, ea)));
    endtask

    // Issue one descriptor and check every beat; beat stall_at is held off for stall_n cycles.
    task automatic do_burst(input string tag, input int a, input int l, input int s,
                            input int b, input int stall_at, input int stall_n);
        bit slv;
        int ea;
        @(negedge ACLK);
        chk({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".idle_valid"}, 32'(beat_valid), 32'd0);
        req_valid = 1'b1;
        req_addr  = a[15:0];
        req_len   = l[7:0];
        req_size  = s[2:0];
        req_burst = b[1:0];
        @(posedge ACLK);
        #1;
        // Garbage descriptor held valid during the burst must be ignored.
        req_valid = 1'b1;
        req_addr  = 16'($urandom);
        req_len   = 8'($urandom);
        req_size  = 3'($urandom);
        req_burst = 2'($urandom);
        slv = model_slverr(a, l, s, b);
        for (int i = 0; i <= l; i++) begin
            ea = model_addr(a, l, s, b, i);
            if (i == stall_at) begin
                beat_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    check_beat({tag, ".stall"}, i, l, ea, slv);
                    @(posedge ACLK);
                    #1;
                end
                beat_ready = 1'b1;
            end
            check_beat(tag, i, l, ea, slv);
            @(posedge ACLK);
            #1;
        end
        req_valid = 1'b0;
        chk({tag, ".done_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".done_busy"}, 32'(busy), 32'd0);
        chk({tag, ".done_valid"}, 32'(beat_valid), 32'd0);
    endtask

    initial begin
        int a;
        int l;
        int s;
        int b;
        int lens[4];
        lens[0] = 1; lens[1] = 3; lens[2] = 7; lens[3] = 15;

        ARESETn    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        req_size   = '0;
        req_burst  = '0;
        beat_ready = 1'b1;
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.beat_valid", 32'(beat_valid), 32'd0);
        chk("rst.beat_addr", 32'(beat_addr), 32'd0);
        chk("rst.beat_num", 32'(beat_num), 32'd0);
        chk("rst.beat_last", 32'(beat_last), 32'd0);
        chk("rst.beat_resp", 32'(beat_resp), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);

        do_burst("incr4",      16'h0004, 3, 2, 1, -1, 0);
        do_burst("wrap4",      16'h0038, 3, 2, 2, -1, 0);
        do_burst("wrap_len2",  16'h0030, 2, 2, 2, -1, 0);
        do_burst("fixed3",     16'h0100, 2, 2, 0, -1, 0);
        do_burst("incr_unal",  16'h0005, 1, 2, 1, -1, 0);
        do_burst("incr_4kb",   16'h0FF8, 3, 2, 1, -1, 0);
        do_burst("size3",      16'h0100, 1, 3, 1, -1, 0);
        do_burst("fixed_dec",  16'h1000, 0, 2, 0, -1, 0);
        do_burst("rsvd",       16'h0200, 1, 2, 3, -1, 0);
        do_burst("wrap_unal",  16'h0032, 3, 2, 2, -1, 0);
        do_burst("stall",      16'h0040, 3, 2, 1, 1, 3);

        // Reset in the middle of a burst.
        @(negedge ACLK);
        req_valid = 1'b1;
        req_addr  = 16'h0200;
        req_len   = 8'd7;
        req_size  = 3'd2;
        req_burst = 2'd1;
        @(posedge ACLK);
        #1;
        req_valid = 1'b0;
        chk("mid.valid0", 32'(beat_valid), 32'd1);
        @(posedge ACLK);
        #1;
        chk("mid.num1", 32'(beat_num), 32'd1);
        ARESETn = 1'b0;
        #1;
        chk("mid.rst_valid", 32'(beat_valid), 32'd0);
        chk("mid.rst_busy", 32'(busy), 32'd0);
        chk("mid.rst_num", 32'(beat_num), 32'd0);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        chk("mid.rel_ready", 32'(req_ready), 32'd1);
        chk("mid.rel_addr", 32'(beat_addr), 32'd0);
        do_burst("post_rst", 16'h0010, 1, 2, 1, -1, 0);

        for (int n = 0; n < 40; n++) begin
            b = int'($urandom_range(0, 3));
            s = int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 16'h1FFF));
            if (b == 2) begin
                l = lens[$urandom_range(0, 3)];
                a = a & ~((1 << s) - 1);
            end else begin
                l = int'($urandom_range(0, 15));
            end
            do_burst("rand", a, l, s, b, int'($urandom_range(0, l + 2)),
                     int'($urandom_range(1, 3)));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
